// File: rtl/jk_counter_pkg.sv
// Mode encodings and types shared by the JK counter slice.
package jk_counter_pkg;

    typedef logic [2:0] jk_mode_t;

    localparam jk_mode_t MODE_HOLD  = 3'b000;
    localparam jk_mode_t MODE_JK    = 3'b001;
    localparam jk_mode_t MODE_UP    = 3'b010;
    localparam jk_mode_t MODE_DOWN  = 3'b011;
    localparam jk_mode_t MODE_LOAD  = 3'b100;
    localparam jk_mode_t MODE_CLEAR = 3'b101;

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle between a JK counter and its user.
interface jk_sync_counter_if #(
    parameter int WIDTH = 8
);
    import jk_counter_pkg::*;

    logic             en;
    jk_mode_t         mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, j, k, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, mode, j, k, load_val,
        output q, tc, wrap
    );

endinterface

// File: rtl/jk_cell.sv
// Single posedge JK flip-flop with synchronous reset and clock enable.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (ce) begin
            unique case ({j, k})
                2'b10:   q_d = 1'b1;
                2'b01:   q_d = 1'b0;
                2'b11:   q_d = ~q_q;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= rst_val;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// WIDTH-bit JK-cell register/counter; every mode is expressed as J/K steering.
// JK_COUNTER_SATURATE_EN: UP/DOWN hold at the boundary instead of wrapping.
module jk_sync_counter
    import jk_counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    jk_sync_counter_if.slave bus
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             tc_w;
    logic             wrap_q;

    // Ripple toggle masks: bit i flips when all lower bits are 1 (up) / 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q_w[i-1];
            dn_t[i] = dn_t[i-1] & ~q_w[i-1];
        end
    end

    assign tc_w = bus.en &
                  (((bus.mode == MODE_UP)   && (q_w == '1)) ||
                   ((bus.mode == MODE_DOWN) && (q_w == '0)));

    always_comb begin
        j_d = '0;
        k_d = '0;
        case (bus.mode)
            MODE_JK: begin
                j_d = bus.j;
                k_d = bus.k;
            end
            MODE_UP: begin
                j_d = up_t;
                k_d = up_t;
            end
            MODE_DOWN: begin
                j_d = dn_t;
                k_d = dn_t;
            end
            MODE_LOAD: begin
                j_d = bus.load_val;
                k_d = ~bus.load_val;
            end
            MODE_CLEAR: begin
                j_d = '0;
                k_d = '1;
            end
            default: begin
                j_d = '0;
                k_d = '0;
            end
        endcase
`ifdef JK_COUNTER_SATURATE_EN
        if (tc_w) begin
            j_d = '0;
            k_d = '0;
        end
`endif
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RESET_VAL[i]),
            .ce      (bus.en),
            .j       (j_d[i]),
            .k       (k_d[i]),
            .q       (q_w[i])
        );
    end

    // tc already carries en, so a disabled edge clears wrap.
    always_ff @(posedge clk) begin
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= tc_w;
    end

    assign bus.q    = q_w;
    assign bus.tc   = tc_w;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter (WIDTH=8, RESET_VAL=8'hA5).
module tb_jk_sync_counter;
    import jk_counter_pkg::*;

`ifdef JK_COUNTER_SATURATE_EN
    localparam bit S = 1'b1;
`else
    localparam bit S = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic [7:0] q;
        logic       tc;
        logic       wrap;
    } exp_t;

    exp_t sb[$];

    jk_sync_counter_if #(.WIDTH(8)) bus ();

    jk_sync_counter #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per edge, checked mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.q !== e.q) begin
                errors++;
                $display("FAIL q: got %h expected %h at %0t", bus.q, e.q, $time);
            end
            checks++;
            if (bus.tc !== e.tc) begin
                errors++;
                $display("FAIL tc: got %b expected %b at %0t", bus.tc, e.tc, $time);
            end
            checks++;
            if (bus.wrap !== e.wrap) begin
                errors++;
                $display("FAIL wrap: got %b expected %b at %0t", bus.wrap, e.wrap, $time);
            end
        end
    end

    task automatic step(input logic rst, input logic en, input jk_mode_t m,
                        input logic [7:0] jj, input logic [7:0] kk,
                        input logic [7:0] lv, input logic [7:0] eq,
                        input logic etc, input logic ew);
        @(negedge clk);
        #1;
        reset        = rst;
        bus.en       = en;
        bus.mode     = m;
        bus.j        = jj;
        bus.k        = kk;
        bus.load_val = lv;
        @(posedge clk);
        sb.push_back('{q: eq, tc: etc, wrap: ew});
    endtask

    initial begin
        logic [7:0] cur;
        bus.en       = 1'b1;
        bus.mode     = MODE_UP;
        bus.j        = '0;
        bus.k        = '0;
        bus.load_val = '0;

        step(1, 1, MODE_UP, 0, 0, 0, 8'hA5, 0, 0);
        step(1, 1, MODE_UP, 0, 0, 0, 8'hA5, 0, 0);

        step(0, 1, MODE_LOAD, 0, 0, 8'h0F, 8'h0F, 0, 0);
        step(0, 1, MODE_JK, 8'hF0, 8'h0C, 0, 8'hF3, 0, 0);
        step(0, 1, MODE_JK, 8'hFF, 8'hFF, 0, 8'h0C, 0, 0);
        step(0, 1, MODE_HOLD, 8'hFF, 8'hFF, 8'h55, 8'h0C, 0, 0);

        step(0, 1, MODE_LOAD, 0, 0, 8'hFE, 8'hFE, 0, 0);
        step(0, 1, MODE_UP, 0, 0, 0, 8'hFF, 1, 0);
        step(0, 1, MODE_UP, 0, 0, 0, S ? 8'hFF : 8'h00, S, 1);
        step(0, 1, MODE_UP, 0, 0, 0, S ? 8'hFF : 8'h01, S, S);

        step(0, 1, MODE_LOAD, 0, 0, 8'h01, 8'h01, 0, 0);
        step(0, 1, MODE_DOWN, 0, 0, 0, 8'h00, 1, 0);
        step(0, 1, MODE_DOWN, 0, 0, 0, S ? 8'h00 : 8'hFF, S, 1);
        step(0, 1, MODE_DOWN, 0, 0, 0, S ? 8'h00 : 8'hFE, S, S);

        cur = S ? 8'h00 : 8'hFE;
        for (int i = 0; i < 5; i++)
            step(0, 0, MODE_UP, 0, 0, 0, cur, 0, 0);
        step(0, 1, 3'b111, 8'hFF, 8'hFF, 8'h33, cur, 0, 0);
        step(0, 1, 3'b110, 8'hFF, 8'hFF, 8'h33, cur, 0, 0);

        step(0, 1, MODE_CLEAR, 0, 0, 8'hFF, 8'h00, 0, 0);
        step(0, 0, MODE_DOWN, 0, 0, 0, 8'h00, 0, 0);

        step(0, 1, MODE_LOAD, 0, 0, 8'hFF, 8'hFF, 0, 0);
        step(0, 0, MODE_UP, 0, 0, 0, 8'hFF, 0, 0);
        step(0, 1, MODE_UP, 0, 0, 0, S ? 8'hFF : 8'h00, S, 1);
        step(0, 1, MODE_UP, 0, 0, 0, S ? 8'hFF : 8'h01, S, S);
        step(0, 1, MODE_CLEAR, 0, 0, 0, 8'h00, 0, 0);

        step(0, 1, MODE_LOAD, 0, 0, 8'hFF, 8'hFF, 0, 0);
        step(0, 1, MODE_UP, 0, 0, 0, S ? 8'hFF : 8'h00, S, 1);
        step(1, 1, MODE_UP, 0, 0, 0, 8'hA5, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
